// File: rtl/booth_seq_mult_rad4_if.sv
// ---------------------------------------------------------------------------
// booth_seq_mult_rad4_if
// Handshake bundle between operand staging, the radix-4 Booth multiplier and
// the result sink.
//
//   in_valid     staging -> mult   operand pair valid
//   in_ready     mult -> staging   multiplier can accept operands
//   in_a         staging -> mult   multiplicand, unsigned, WA bits
//   in_b         staging -> mult   multiplier, unsigned, WB bits
//   out_valid    mult -> sink      product valid
//   out_ready    sink -> mult      sink accepts product
//   out_product  mult -> sink      unsigned product, WA+WB bits
//   busy         mult -> observer  operation in flight or result pending
//
// master: the side that supplies operands and sinks results.
// slave : the multiplier itself.
// ---------------------------------------------------------------------------
interface booth_seq_mult_rad4_if #(
    parameter int WA = 11,
    parameter int WB = 11
);
    logic               in_valid;
    logic               in_ready;
    logic [WA-1:0]      in_a;
    logic [WB-1:0]      in_b;
    logic               out_valid;
    logic               out_ready;
    logic [WA+WB-1:0]   out_product;
    logic               busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/booth_seq_mult_rad4.sv
// ---------------------------------------------------------------------------
// booth_seq_mult_rad4
// Iterative radix-4 Booth multiplier: unsigned 11-bit A times unsigned WB-bit
// B. One Booth digit of B is scanned per clock through a single
// booth_encoder_rad4 instance; the selected partial product (0, +-A, +-2A) is
// shifted into place and accumulated. The product is presented on a
// valid/ready output and held until the sink takes it.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   bus   slave modport of booth_seq_mult_rad4_if
//           in_valid/in_ready/in_a/in_b        operand handshake
//           out_valid/out_ready/out_product    result handshake
//           busy                               high while RUN or DONE
//
// Timing: out_valid rises NDIG edges after the accepting edge; one product
// per NDIG+2 cycles at best (accept, NDIG digit steps, output transfer).
// ---------------------------------------------------------------------------

// Radix-4 Booth digit encoder. Digit {b_next, b_n, b_prev} selects
// 0, +A, +2A, -A or -2A. Negative selections are returned one's-complemented
// with neg=1; the consumer completes the negation by adding neg, so
// {neg, A_out} + neg is the signed 13-bit partial product.
module booth_encoder_rad4 (
    input  logic        b_prev,
    input  logic        b_n,
    input  logic        b_next,
    input  logic [10:0] A,
    output logic [11:0] A_out,
    output logic        neg
);
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        A_out = '0;
        neg   = 1'b0;
        unique case ({b_next, b_n, b_prev})
            3'b001, 3'b010: A_out = {1'b0, A};
            3'b011:         A_out = {A, 1'b0};
            3'b100: begin
                A_out = ~{A, 1'b0};
                neg   = 1'b1;
            end
            3'b101, 3'b110: begin
                A_out = ~{1'b0, A};
                neg   = 1'b1;
            end
            default: ;  // 000 / 111: digit is zero, neg stays 0
        endcase
    end
endmodule

module booth_seq_mult_rad4 #(
    parameter int WB = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_seq_mult_rad4_if.slave  bus
);
    // Multiplicand width is pinned by the encoder's A port.
    localparam int WA   = 11;
    localparam int NDIG = (WB + 2) / 2;
    localparam int WP   = WA + WB;
    localparam int WX   = 2 * NDIG + 1;          // B with b_prev and zero pad
    localparam int WACC = WP + 3;                // signed accumulator width
    localparam int WCNT = (NDIG > 2) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WA-1:0]     a_q;
    logic [WX-1:0]     bx_q;
    logic [WACC-1:0]   acc;
    logic [WCNT-1:0]   cnt;

    // Current three-bit digit window of bx_q, selected by cnt.
    logic [2:0]        digit;
    logic [11:0]       a_out;
    logic              neg;
    logic [12:0]       pp;
    logic [WACC-1:0]   pp_ext;
    logic [WACC-1:0]   acc_next;

    always_comb begin
        digit = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (cnt == WCNT'(d)) digit = bx_q[2*d +: 3];
        end
    end

    booth_encoder_rad4 u_enc (
        .b_prev (digit[0]),
        .b_n    (digit[1]),
        .b_next (digit[2]),
        .A      (a_q),
        .A_out  (a_out),
        .neg    (neg)
    );

    // {neg, A_out} is the one's complement of the magnitude for negative
    // digits; adding neg turns it into the two's-complement partial product.
    assign pp       = {neg, a_out} + {12'b0, neg};
    assign pp_ext   = {{(WACC-13){pp[12]}}, pp};
    // Accumulator wraps in two's complement; intermediate sums may be
    // negative, the final sum is always in [0, 2^WP).
    assign acc_next = acc + (pp_ext << {cnt, 1'b0});

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.out_product <= '0;
            acc             <= '0;
            cnt             <= '0;
            // NOTE: a_q and bx_q are left out of reset on purpose; they are
            // always loaded on accept before anything reads them.
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.in_a;
                        bx_q         <= {{(WX-WB-1){1'b0}}, bus.in_b, 1'b0};
                        acc          <= '0;
                        cnt          <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + WCNT'(1);
                    if (cnt == WCNT'(NDIG - 1)) begin
                        state           <= DONE;
                        bus.out_valid   <= 1'b1;
                        bus.out_product <= acc_next[WP-1:0];
                    end
                end
                DONE: begin
                    // in_valid is not looked at here; a pending operand is
                    // taken on the first IDLE cycle after the transfer.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_mult_rad4.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mult_rad4
// Directed vectors with hand-computed products, plus a randomised stream with
// idle gaps and sink back-pressure. A reference queue holds a*b for every
// accepted operand pair; one monitor compares each presented product against
// it and flushes it on reset.
// ---------------------------------------------------------------------------
module tb_booth_seq_mult_rad4;
    localparam int WA = 11;
    localparam int WB = 11;
    localparam int WP = WA + WB;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    booth_seq_mult_rad4_if #(.WA(WA), .WB(WB)) bus ();

    booth_seq_mult_rad4 #(.WB(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int received    = 0;
    logic [WP-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference model and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready_vs_busy", bus.in_ready, !bus.busy);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    check("product_vs_model", bus.out_product, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        received++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({11'b0, bus.in_a} * {11'b0, bus.in_b});
        end
    end

    // One directed operation; hold = cycles the sink stalls after out_valid.
    task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b,
                         input logic [WP-1:0] exp, input int hold);
        int n = 0;
        int lat = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("wait_in_ready_timeout", 1'b0, 1'b1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, 6);
        check("product", bus.out_product, exp);
        for (int i = 0; i < hold; i++) begin
            bus.in_a = ~a;  // operand changes while busy must be ignored
            @(posedge clk); #1;
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_product", bus.out_product, exp);
            check("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("after_xfer_out_valid", bus.out_valid, 1'b0);
        check("after_xfer_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic producer();
        for (int i = 0; i < NRAND; i++) begin
            int n = 0;
            logic acc_now;
            repeat ($urandom_range(0, 2)) begin
                bus.in_a = WA'($urandom);
                bus.in_b = WB'($urandom);
                @(posedge clk); #1;
            end
            bus.in_a     = WA'($urandom);
            bus.in_b     = WB'($urandom);
            bus.in_valid = 1'b1;
            acc_now      = 1'b0;
            while (!acc_now && n < 100) begin
                acc_now = bus.in_ready;
                @(posedge clk); #1; n++;
            end
            bus.in_valid = 1'b0;
            if (!acc_now) check("producer_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic consumer();
        int cyc = 0;
        while (received < NRAND && cyc < 60000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; cyc++;
        end
        bus.out_ready = 1'b0;
        check("random_results_received", received, NRAND);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_product", bus.out_product, 0);

        // 2-4. directed vectors
        do_op(11'h7FF, 11'h7FF, 22'h3FF001, 0);
        do_op(11'h555, 11'h2AA, 22'h0E3472, 0);
        do_op(11'h001, 11'h001, 22'h000001, 0);
        do_op(11'h000, 11'h5A5, 22'h000000, 0);
        do_op(11'h7FF, 11'h400, 22'h1FFC00, 5);

        // 5. reset mid-operation discards it
        bus.in_a     = 11'h123;
        bus.in_b     = 11'h456;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_out_product", bus.out_product, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("midrst_no_out_valid", bus.out_valid, 1'b0);
        end
        do_op(11'd3, 11'd5, 22'hF, 0);

        // 6. random stream with gaps and back-pressure
        received = 0;
        fork
            producer();
            consumer();
        join
        repeat (3) @(posedge clk);
        #1 check("model_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
